// File: rtl/cs4344_i2s_sequencer_if.sv
// Sample-pair source bus for the CS4344 sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: the sequencer pulses s_ready once per frame; a pair moves when s_valid && s_ready.
// Ports: s_valid, s_left[23:0], s_right[23:0] (source -> sequencer), s_ready (sequencer -> source).
// Modports: master = audio source, slave = sequencer.
interface cs4344_i2s_sequencer_if;
  logic        s_valid;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        s_ready;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/cs4344_i2s_sequencer.sv
// CS4344 I2S sequencer: derives MCLK/SCLK/LRCK, warms the DAC up muted, then streams 24-bit pairs.
// Latency: handshake at the frame boundary -> left MSB on SDIN 4 MCLK later.
// Backpressure: s_ready is a one-Clk strobe per frame; an absent pair sends silence and sets underrun.
// Ports: Clk, Rst_n (async active-low), enable, src (slave modport of cs4344_i2s_sequencer_if),
//        clr_underrun, underrun, busy, MCLK, SCLK, LRCK, SDIN.
// Optional: define CS4344_ATTEN_EN to add atten[3:0], an arithmetic right shift applied at latch time.
module cs4344_i2s_sequencer #(
  parameter int MCLK_HALF     = 1,
  parameter int WARMUP_FRAMES = 4
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         enable,
  cs4344_i2s_sequencer_if.slave        src,
`ifdef CS4344_ATTEN_EN
  input  logic [3:0]                   atten,
`endif
  input  logic                         clr_underrun,
  output logic                         underrun,
  output logic                         busy,
  output logic                         MCLK,
  output logic                         SCLK,
  output logic                         LRCK,
  output logic                         SDIN
);

  localparam int TW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t      state;
  logic [TW-1:0] tc;
  logic [7:0]  fc;
  logic [7:0]  wcnt;
  logic [23:0] smp_l;
  logic [23:0] smp_r;

  logic        tick;
  logic        rise;
  logic        bnd;
  logic        last_warm;
  logic        fetch;
  logic [7:0]  fc_nx;
  logic [4:0]  slot;
  logic [4:0]  bit_idx;
  logic [23:0] sel;
  logic        data_bit;
  logic [23:0] lat_l;
  logic [23:0] lat_r;

  // Strobes are decoded from registered state; `rise` marks the cycle whose
  // closing edge takes MCLK high, `bnd` the rise that wraps fc 255->0.
  assign tick      = (tc == TW'(MCLK_HALF - 1));
  assign rise      = (state != IDLE) && tick && !MCLK;
  assign bnd       = rise && (fc == 8'hFF);
  assign last_warm = (wcnt == 8'(WARMUP_FRAMES - 1));
  assign fc_nx     = fc + 8'd1;

  // The fetch is offered on the boundary itself, so s_ready follows enable
  // combinationally: a stop requested before the boundary suppresses it.
  assign fetch     = bnd && enable && ((state == RUN) || ((state == WARMUP) && last_warm));
  assign src.s_ready = fetch;

  always_comb begin
    lat_l = 24'd0;
    lat_r = 24'd0;
    if (src.s_valid) begin
`ifdef CS4344_ATTEN_EN
      lat_l = 24'($signed(src.s_left)  >>> atten);
      lat_r = 24'($signed(src.s_right) >>> atten);
`else
      lat_l = src.s_left;
      lat_r = src.s_right;
`endif
    end
  end

  // Slot 0 is the I2S one-bit delay; slots 1..24 carry bits 23..0.
  always_comb begin
    slot     = fc_nx[6:2];
    sel      = fc_nx[7] ? smp_r : smp_l;
    bit_idx  = 5'd24 - slot;
    data_bit = 1'b0;
    if ((state == RUN) && (slot != 5'd0) && (slot <= 5'd24))
      data_bit = sel[bit_idx];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      tc       <= '0;
      fc       <= 8'd0;
      wcnt     <= 8'd0;
      smp_l    <= 24'd0;
      smp_r    <= 24'd0;
      MCLK     <= 1'b0;
      SCLK     <= 1'b0;
      LRCK     <= 1'b0;
      SDIN     <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Set wins over clear.
      if (fetch && !src.s_valid)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;

      case (state)
        IDLE: begin
          tc   <= '0;
          fc   <= 8'd0;
          wcnt <= 8'd0;
          MCLK <= 1'b0;
          SCLK <= 1'b0;
          LRCK <= 1'b0;
          SDIN <= 1'b0;
          if (enable) begin
            state <= WARMUP;
            busy  <= 1'b1;
          end
        end
        default: begin
          tc <= tick ? '0 : tc + TW'(1);
          if (tick)
            MCLK <= ~MCLK;
          if (rise) begin
            fc   <= fc_nx;
            SCLK <= fc_nx[1];
            LRCK <= fc_nx[7];
            // fc[1:0] returning to 0 is the SCLK falling edge.
            if (fc_nx[1:0] == 2'd0)
              SDIN <= data_bit;
          end
          if (bnd) begin
            if (!enable) begin
              // Frame finished with stop requested: park every pin low.
              state <= IDLE;
              busy  <= 1'b0;
              MCLK  <= 1'b0;
              tc    <= '0;
              wcnt  <= 8'd0;
              smp_l <= 24'd0;
              smp_r <= 24'd0;
            end else if (state == WARMUP) begin
              if (last_warm)
                state <= RUN;
              else
                wcnt <= wcnt + 8'd1;
            end
            if (fetch) begin
              smp_l <= lat_l;
              smp_r <= lat_r;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs4344_i2s_sequencer.sv
// Bench for cs4344_i2s_sequencer with MCLK_HALF=1, WARMUP_FRAMES=2.
// Timeline model: n = Clk cycles since busy rose; MCLK = n%2, fc = ((n+1)/2)%256,
// boundaries at n%512==510, first fetch at n=1022, frame j emitted from n=1023+512*j.
module tb_cs4344_i2s_sequencer;

  localparam int NF = 6;

  logic Clk = 1'b0;
  logic Rst_n;
  logic enable;
  logic clr_underrun;
  logic underrun, busy, MCLK, SCLK, LRCK, SDIN;
`ifdef CS4344_ATTEN_EN
  logic [3:0] atten = 4'd0;
`endif

  cs4344_i2s_sequencer_if sif ();

  cs4344_i2s_sequencer #(.MCLK_HALF(1), .WARMUP_FRAMES(2)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .enable       (enable),
    .src          (sif.slave),
`ifdef CS4344_ATTEN_EN
    .atten        (atten),
`endif
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .busy         (busy),
    .MCLK         (MCLK),
    .SCLK         (SCLK),
    .LRCK         (LRCK),
    .SDIN         (SDIN)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        valid;
    logic [23:0] left;
    logic [23:0] right;
    logic        clr_mid;    // pulse clr_underrun 50 cycles into the frame
    logic        clr_fetch;  // pulse clr_underrun on the fetch cycle itself
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t tbl [NF];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic ur_e   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] pins();
    return {MCLK, SCLK, LRCK, SDIN, busy, underrun};
  endfunction

  function automatic logic [23:0] shape(input logic v, input logic [23:0] x);
    logic [23:0] r;
    r = v ? x : 24'd0;
`ifdef CS4344_ATTEN_EN
    r = 24'($signed(r) >>> atten);
`endif
    return r;
  endfunction

  function automatic logic sdin_exp(input int n);
    int          jj;
    logic [7:0]  fc;
    int          slot;
    logic [23:0] w;
    if (n < 1023) return 1'b0;
    jj   = (n - 1023) / 512;
    fc   = 8'((n + 1) / 2);
    slot = int'(fc[6:2]);
    w    = fc[7] ? tbl[jj].exp_r : tbl[jj].exp_l;
    if (slot >= 1 && slot <= 24) return w[24 - slot];
    return 1'b0;
  endfunction

  // Runs one enable session from the cycle busy rises (n=0) through n_end.
  // n_stop: cycle at which enable is dropped (-1 = never).
  task automatic run(input int n_end, input int n_stop);
    bit          running;
    bit          fetch_e;
    int          j, jc, jj, slot;
    logic [7:0]  fc_e;
    logic [5:0]  ev;
    logic        prev_sdin, prev_sclk;
    logic [23:0] cap_l, cap_r;
    running   = 1'b1;
    prev_sdin = SDIN;
    prev_sclk = SCLK;
    cap_l     = 24'd0;
    cap_r     = 24'd0;
    for (int n = 0; n <= n_end; n++) begin
      @(posedge Clk); #1;
      fc_e = 8'((n + 1) / 2);
      if (running)
        ev = {1'(n % 2), fc_e[1], fc_e[7], sdin_exp(n), 1'b1, ur_e};
      else
        ev = {5'b0, ur_e};
      check("pins", 32'(pins()), 32'(ev));
      if (SDIN !== prev_sdin)
        check("sdin_only_on_sclk_fall", {30'd0, prev_sclk, SCLK}, 32'b10);
      prev_sdin = SDIN;
      prev_sclk = SCLK;

      if (running && n >= 1023) begin
        jj   = (n - 1023) / 512;
        slot = int'(fc_e[6:2]);
        if (fc_e[1:0] == 2'd2 && slot >= 1 && slot <= 24) begin
          if (fc_e[7]) cap_r[24 - slot] = SDIN;
          else         cap_l[24 - slot] = SDIN;
        end
        if ((n - 1023) % 512 == 511) begin
          check("frame_left_word",  32'(cap_l), 32'(tbl[jj].exp_l));
          check("frame_right_word", 32'(cap_r), 32'(tbl[jj].exp_r));
        end
      end

      // Inputs for cycle n: present the pair for the next fetch.
      j  = (n <= 1022) ? 0 : (n - 1023) / 512 + 1;
      if (j > NF - 1) j = NF - 1;
      jc = (n >= 1023) ? (n - 1023) / 512 : 0;
      if (jc > NF - 1) jc = NF - 1;
      sif.s_valid  = tbl[j].valid;
      sif.s_left   = tbl[j].left;
      sif.s_right  = tbl[j].right;
      clr_underrun = (n >= 1023 && (n - 1023) % 512 == 50 && tbl[jc].clr_mid) ||
                     (n >= 1022 && n % 512 == 510 && tbl[j].clr_fetch);
      if (n == n_stop) enable = 1'b0;
      #1;
      fetch_e = running && enable && n >= 1022 && (n % 512 == 510);
      check("s_ready", 32'(sif.s_ready), 32'(fetch_e));
      if (running && (n % 512 == 510) && !enable) running = 1'b0;
      ur_e = (fetch_e && !tbl[j].valid) ? 1'b1 : (clr_underrun ? 1'b0 : ur_e);
    end
    clr_underrun = 1'b0;
  endtask

  task automatic idle_check(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clk); #1;
      check(name, 32'(pins()), 32'({5'b0, ur_e}));
      check({name, "_ready"}, 32'(sif.s_ready), 32'd0);
    end
  endtask

  initial begin
    Rst_n        = 1'b0;
    enable       = 1'b0;
    clr_underrun = 1'b0;
    sif.s_valid  = 1'b0;
    sif.s_left   = 24'd0;
    sif.s_right  = 24'd0;

    tbl[0] = '{1'b1, 24'h800001, 24'h7FFFFE, 1'b0, 1'b0, 24'd0, 24'd0};
    tbl[1] = '{1'b0, 24'h123456, 24'h654321, 1'b1, 1'b0, 24'd0, 24'd0};
    tbl[2] = '{1'b0, 24'hABCDEF, 24'hFEDCBA, 1'b0, 1'b0, 24'd0, 24'd0};
    tbl[3] = '{1'b0, 24'h000001, 24'hFFFFFF, 1'b1, 1'b1, 24'd0, 24'd0};
    tbl[4] = '{1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0, 24'd0, 24'd0};
    tbl[5] = '{1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom), 1'b0, 1'b0, 24'd0, 24'd0};
    for (int i = 0; i < NF; i++) begin
      tbl[i].exp_l = shape(tbl[i].valid, tbl[i].left);
      tbl[i].exp_r = shape(tbl[i].valid, tbl[i].right);
    end

    repeat (3) @(posedge Clk);
    #1;
    check("reset_pins", 32'(pins()), 32'd0);
    check("reset_ready", 32'(sif.s_ready), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    idle_check(4, "idle_before_enable");

    // Full session: warm-up, six frames, stop requested at fc=100 of the last.
    enable = 1'b1;
    run(1022 + 512 * NF + 6, 1223 + 512 * (NF - 1));
    idle_check(5, "idle_after_stop");

    // Restart repeats the warm-up; then async reset mid-frame in RUN.
    enable = 1'b1;
    run(1023 + 300, -1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    ur_e = 1'b0;
    check("async_reset_pins", 32'(pins()), 32'd0);
    check("async_reset_ready", 32'(sif.s_ready), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("post_reset_idle", 32'(pins()), 32'd0);
    run(1100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
